// File: rtl/fir_drv_pkg.sv
// Shared types and default sizing for the FIR sample driver.
package fir_drv_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StHold  = 2'd3
  } state_e;

  localparam int unsigned DefaultDataW   = 16;
  localparam int unsigned DefaultOutW    = 38;
  localparam int unsigned DefaultFirSize = 64;

  // Allow the full tap pipeline plus some controller slack before giving up.
  function automatic int unsigned default_timeout(input int unsigned fir_size);
    return fir_size + 16;
  endfunction

  localparam int unsigned DefaultTimeout = default_timeout(DefaultFirSize);

endpackage

// File: rtl/fir_sample_driver_if.sv
// Sample-in, FIR-facing and result-out signals of the FIR sample driver.
interface fir_sample_driver_if
  import fir_drv_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW,
  parameter int unsigned OUT_W  = DefaultOutW
) ();

  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] fir_in_data;
  logic              fir_input_valid;
  logic              fir_output_valid;
  logic [OUT_W-1:0]  fir_out_data;
  logic [OUT_W-1:0]  m_data;
  logic              m_valid;
  logic              m_ready;

  modport master (
    input  s_data, s_valid, fir_output_valid, fir_out_data, m_ready,
    output s_ready, fir_in_data, fir_input_valid, m_data, m_valid
  );

  modport slave (
    output s_data, s_valid, fir_output_valid, fir_out_data, m_ready,
    input  s_ready, fir_in_data, fir_input_valid, m_data, m_valid
  );

endinterface

// File: rtl/sample_fifo.sv
// Small power-of-two FIFO with combinational head read and async active-high reset.
module sample_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CntW-1:0]  count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign full     = (count_q == CntW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem_q[rd_ptr_q];

  // Storage needs no reset; count and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/fir_sample_driver.sv
// Feeds buffered samples to the FIR one at a time and hands each result downstream.
module fir_sample_driver
  import fir_drv_pkg::*;
#(
  parameter int unsigned DATA_W     = DefaultDataW,
  parameter int unsigned OUT_W      = DefaultOutW,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned FIR_SIZE   = DefaultFirSize,
  parameter int unsigned TIMEOUT    = default_timeout(FIR_SIZE)
) (
  input  logic                clk,
  input  logic                rst,
  fir_sample_driver_if.master bus,
  output logic                busy,
  output logic                err_timeout,
  output logic                err_stray
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

  state_e            state_q;
  logic [DATA_W-1:0] fir_in_data_q;
  logic [OUT_W-1:0]  m_data_q;
  logic              m_valid_q;
  logic [TmoW-1:0]   tmo_cnt_q;
  logic              err_timeout_q, err_stray_q;

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_pop_data;
  logic [CntW-1:0]   fifo_count;

  assign fifo_push = bus.s_valid && !fifo_full;
  assign fifo_pop  = (state_q == StIdle) && !fifo_empty;

  sample_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_sample_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (bus.s_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_pop_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      fir_in_data_q <= '0;
      m_data_q      <= '0;
      m_valid_q     <= 1'b0;
      tmo_cnt_q     <= '0;
      err_timeout_q <= 1'b0;
      err_stray_q   <= 1'b0;
    end else begin
      if (bus.fir_output_valid && (state_q != StWait)) err_stray_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (!fifo_empty) begin
            fir_in_data_q <= fifo_pop_data;
            state_q       <= StIssue;
          end
        end
        StIssue: begin
          tmo_cnt_q <= '0;
          state_q   <= StWait;
        end
        StWait: begin
          tmo_cnt_q <= tmo_cnt_q + 1'b1;
          // A result arriving on the last allowed cycle still counts.
          if (bus.fir_output_valid) begin
            m_data_q  <= bus.fir_out_data;
            m_valid_q <= 1'b1;
            state_q   <= StHold;
          end else if (tmo_cnt_q == TmoW'(TIMEOUT - 1)) begin
            err_timeout_q <= 1'b1;
            state_q       <= StIdle;
          end
        end
        StHold: begin
          if (bus.m_ready) begin
            m_valid_q <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.s_ready         = (fifo_count != CntW'(FIFO_DEPTH));
  assign bus.fir_in_data     = fir_in_data_q;
  assign bus.fir_input_valid = (state_q == StIssue);
  assign bus.m_data          = m_data_q;
  assign bus.m_valid         = m_valid_q;
  assign busy                = (state_q != StIdle);
  assign err_timeout         = err_timeout_q;
  assign err_stray           = err_stray_q;

endmodule

// File: tb/tb_fir_sample_driver.sv
// Randomised self-checking bench for fir_sample_driver with a cycle-level FIR responder model.
module tb_fir_sample_driver;
  import fir_drv_pkg::*;

  localparam int unsigned DW    = 16;
  localparam int unsigned OW    = 38;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned TMO   = 80;

  logic clk;
  logic rst;
  logic busy, err_timeout, err_stray;

  fir_sample_driver_if #(.DATA_W(DW), .OUT_W(OW)) bus ();

  fir_sample_driver #(
    .DATA_W     (DW),
    .OUT_W      (OW),
    .FIFO_DEPTH (DEPTH),
    .FIR_SIZE   (64),
    .TIMEOUT    (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .busy        (busy),
    .err_timeout (err_timeout),
    .err_stray   (err_stray)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned cyc      = 0;

  // FIR responder model state
  bit          resp_en   = 1'b1;
  int unsigned lat       = 67;
  bit          pending   = 1'b0;
  int unsigned due       = 0;
  logic [DW-1:0] pdata   = '0;
  bit          stray_req = 1'b0;

  // Observation records
  int unsigned   pulse_q[$];
  int unsigned   acc_q[$];
  logic [OW-1:0] got_q[$];
  int unsigned   fiv_hi = 0;
  int unsigned   mv_hi  = 0;
  bit            prev_fiv = 1'b0;

  function automatic logic [OW-1:0] fir_model(input logic [DW-1:0] d);
    return 38'hABCDEF ^ OW'(d) ^ 38'h1234;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Responder drive: inputs change 1 time unit after the rising edge.
  initial begin
    bus.fir_output_valid = 1'b0;
    bus.fir_out_data     = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.fir_output_valid = 1'b0;
      bus.fir_out_data     = OW'({$urandom(), $urandom()});
      if (rst) begin
        pending = 1'b0;
      end else if (pending && cyc == due) begin
        bus.fir_output_valid = 1'b1;
        bus.fir_out_data     = fir_model(pdata);
        pending              = 1'b0;
      end
      if (stray_req) begin
        bus.fir_output_valid = 1'b1;
        stray_req            = 1'b0;
      end
    end
  end

  // Observation on the falling edge.
  initial forever begin
    @(negedge clk);
    if (bus.fir_input_valid === 1'b1) begin
      fiv_hi++;
      if (!prev_fiv) begin
        pulse_q.push_back(cyc);
        if (resp_en) begin
          pending = 1'b1;
          due     = cyc + lat;
          pdata   = bus.fir_in_data;
        end
      end
    end
    prev_fiv = (bus.fir_input_valid === 1'b1);
    if (bus.m_valid === 1'b1) begin
      mv_hi++;
      if (bus.m_ready === 1'b1) begin
        got_q.push_back(bus.m_data);
        acc_q.push_back(cyc);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    pulse_q.delete();
    acc_q.delete();
    got_q.delete();
    fiv_hi = 0;
    mv_hi  = 0;
  endtask

  // Leaves s_valid asserted so consecutive calls push back-to-back.
  task automatic push(input logic [DW-1:0] d, output int unsigned c, output bit acc);
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    c           = cyc;
    @(negedge clk);
    acc = bus.s_ready;
    step();
  endtask

  task automatic wait_results(input int k, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (got_q.size() >= k) ok = 1'b1;
      else step();
    end
    if (got_q.size() >= k) ok = 1'b1;
  endtask

  task automatic test_reset();
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b1;
    rst = 1'b0;
    #1 rst = 1'b1;
    step();
    step();
    n_checks++;
    if ({bus.s_ready, bus.fir_input_valid, bus.m_valid, busy, err_timeout, err_stray}
        !== 6'b100000) begin
      n_fail++;
      $display("FAIL reset_flags got %b want 100000", {bus.s_ready, bus.fir_input_valid,
               bus.m_valid, busy, err_timeout, err_stray});
    end
    n_checks++;
    if (bus.fir_in_data !== '0) begin
      n_fail++;
      $display("FAIL reset_fir_in_data got %h want 0", bus.fir_in_data);
    end
    n_checks++;
    if (bus.m_data !== '0) begin
      n_fail++;
      $display("FAIL reset_m_data got %h want 0", bus.m_data);
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step();
    n_checks++;
    if (pulse_q.size() != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle pulses %0d busy %b want 0 and 0", pulse_q.size(), busy);
    end
  endtask

  task automatic test_single();
    int unsigned c;
    bit acc, ok;
    clear_mon();
    lat = 67;
    resp_en = 1'b1;
    bus.m_ready = 1'b1;
    push(16'h1234, c, acc);
    bus.s_valid = 1'b0;
    wait_results(1, 300, ok);
    for (int i = 0; i < 5; i++) step();
    n_checks++;
    if (!(ok && acc)) begin
      n_fail++;
      $display("FAIL single_done got ok=%b acc=%b want 1 1", ok, acc);
    end
    n_checks++;
    if (pulse_q.size() != 1 || pulse_q[0] != c + 2) begin
      n_fail++;
      $display("FAIL single_pulse_time got n=%0d at %0d want n=1 at %0d", pulse_q.size(),
               (pulse_q.size() > 0) ? pulse_q[0] : 0, c + 2);
    end
    n_checks++;
    if (fiv_hi != 1) begin
      n_fail++;
      $display("FAIL single_pulse_width got %0d want 1", fiv_hi);
    end
    n_checks++;
    if (got_q.size() != 1 || got_q[0] !== 38'h00ABCDEF) begin
      n_fail++;
      $display("FAIL single_result got %h want 00abcdef", (got_q.size() > 0) ? got_q[0] : 'x);
    end
    n_checks++;
    if (acc_q.size() != 1 || acc_q[0] != c + 2 + 67 + 1) begin
      n_fail++;
      $display("FAIL single_m_valid_time got %0d want %0d",
               (acc_q.size() > 0) ? acc_q[0] : 0, c + 70);
    end
    n_checks++;
    if (mv_hi != 1) begin
      n_fail++;
      $display("FAIL single_m_valid_width got %0d want 1", mv_hi);
    end
  endtask

  task automatic test_burst();
    logic [DW-1:0] d [10];
    bit [9:0]      acc_v;
    int unsigned   c;
    bit            acc, ok;
    clear_mon();
    lat = $urandom_range(10, 67);
    resp_en = 1'b1;
    bus.m_ready = 1'b1;
    // Entry 0 occupies the FIR so the next eight accumulate in the FIFO.
    for (int i = 0; i < 10; i++) begin
      d[i] = DW'($urandom());
      push(d[i], c, acc);
      acc_v[i] = acc;
    end
    bus.s_valid = 1'b0;
    n_checks++;
    if (acc_v !== 10'b01_1111_1111) begin
      n_fail++;
      $display("FAIL burst_accept got %b want 0111111111", acc_v);
    end
    wait_results(9, 9 * (lat + 10) + 50, ok);
    for (int i = 0; i < 10; i++) step();
    n_checks++;
    if (!ok || got_q.size() != 9 || pulse_q.size() != 9) begin
      n_fail++;
      $display("FAIL burst_count got results %0d pulses %0d want 9 9", got_q.size(),
               pulse_q.size());
    end
    for (int i = 0; i < 9; i++) begin
      n_checks++;
      if (got_q.size() <= i || got_q[i] !== fir_model(d[i])) begin
        n_fail++;
        $display("FAIL burst_order[%0d] got %h want %h", i,
                 (got_q.size() > i) ? got_q[i] : 'x, fir_model(d[i]));
      end
    end
    for (int i = 1; i < 9; i++) begin
      n_checks++;
      if (pulse_q.size() <= i || acc_q.size() < i || pulse_q[i] != acc_q[i-1] + 2) begin
        n_fail++;
        $display("FAIL burst_spacing[%0d] got pulse %0d want %0d", i,
                 (pulse_q.size() > i) ? pulse_q[i] : 0,
                 (acc_q.size() >= i) ? acc_q[i-1] + 2 : 0);
      end
    end
  endtask

  task automatic test_back_pressure();
    logic [DW-1:0] d0, d1;
    logic [OW-1:0] held;
    int unsigned   c, a;
    int            bad;
    bit            acc, ok;
    clear_mon();
    lat = $urandom_range(5, 30);
    resp_en = 1'b1;
    bus.m_ready = 1'b0;
    d0 = DW'($urandom());
    d1 = DW'($urandom());
    push(d0, c, acc);
    push(d1, c, acc);
    bus.s_valid = 1'b0;
    for (int i = 0; i < 100 && bus.m_valid !== 1'b1; i++) step();
    held = bus.m_data;
    n_checks++;
    if (bus.m_valid !== 1'b1 || held !== fir_model(d0)) begin
      n_fail++;
      $display("FAIL bp_first_result got v=%b %h want v=1 %h", bus.m_valid, held,
               fir_model(d0));
    end
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.m_valid !== 1'b1 || bus.m_data !== held) bad++;
      step();
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL bp_hold_stable got %0d unstable cycles want 0", bad);
    end
    n_checks++;
    if (pulse_q.size() != 1) begin
      n_fail++;
      $display("FAIL bp_no_issue got %0d pulses want 1", pulse_q.size());
    end
    a = cyc;
    bus.m_ready = 1'b1;
    wait_results(2, lat + 60, ok);
    n_checks++;
    if (acc_q.size() < 1 || acc_q[0] != a || pulse_q.size() < 2 || pulse_q[1] != a + 2) begin
      n_fail++;
      $display("FAIL bp_release_issue got pulse %0d want %0d",
               (pulse_q.size() > 1) ? pulse_q[1] : 0, a + 2);
    end
    n_checks++;
    if (!ok || got_q[1] !== fir_model(d1)) begin
      n_fail++;
      $display("FAIL bp_second_result got %h want %h", (got_q.size() > 1) ? got_q[1] : 'x,
               fir_model(d1));
    end
  endtask

  task automatic test_timeout_boundary();
    logic [DW-1:0] d;
    int unsigned   c;
    bit            acc, ok;
    clear_mon();
    lat = TMO;
    resp_en = 1'b1;
    bus.m_ready = 1'b1;
    d = DW'($urandom());
    push(d, c, acc);
    bus.s_valid = 1'b0;
    wait_results(1, TMO + 40, ok);
    n_checks++;
    if (!ok || got_q[0] !== fir_model(d) || acc_q[0] != c + 2 + TMO + 1) begin
      n_fail++;
      $display("FAIL tmo_edge_result got %h at %0d want %h at %0d",
               (got_q.size() > 0) ? got_q[0] : 'x, (acc_q.size() > 0) ? acc_q[0] : 0,
               fir_model(d), c + 3 + TMO);
    end
    n_checks++;
    if (err_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_edge_no_err got %b want 0", err_timeout);
    end
  endtask

  task automatic test_timeout();
    logic [DW-1:0] d0, d1;
    int unsigned   c, p0;
    bit            acc, ok;
    clear_mon();
    resp_en = 1'b0;
    bus.m_ready = 1'b1;
    d0 = DW'($urandom());
    d1 = DW'($urandom());
    push(d0, c, acc);
    push(d1, p0, acc);
    bus.s_valid = 1'b0;
    p0 = c + 2;
    while (cyc < p0 + TMO) step();
    n_checks++;
    if ({err_timeout, busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL tmo_before got err=%b busy=%b want 0 1", err_timeout, busy);
    end
    step();
    n_checks++;
    if ({err_timeout, busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL tmo_expire got err=%b busy=%b want 1 0", err_timeout, busy);
    end
    resp_en = 1'b1;
    lat = $urandom_range(3, 40);
    wait_results(1, lat + 40, ok);
    for (int i = 0; i < 5; i++) step();
    n_checks++;
    if (pulse_q.size() != 2 || pulse_q[1] != p0 + TMO + 2) begin
      n_fail++;
      $display("FAIL tmo_next_issue got %0d want %0d", (pulse_q.size() > 1) ? pulse_q[1] : 0,
               p0 + TMO + 2);
    end
    n_checks++;
    if (!ok || got_q.size() != 1 || got_q[0] !== fir_model(d1)) begin
      n_fail++;
      $display("FAIL tmo_next_result got %h want %h", (got_q.size() > 0) ? got_q[0] : 'x,
               fir_model(d1));
    end
    n_checks++;
    if (err_timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_sticky got %b want 1", err_timeout);
    end
  endtask

  task automatic test_stray(input logic [OW-1:0] last_res);
    clear_mon();
    n_checks++;
    if (err_stray !== 1'b0) begin
      n_fail++;
      $display("FAIL stray_pre got %b want 0", err_stray);
    end
    stray_req = 1'b1;
    for (int i = 0; i < 4; i++) step();
    n_checks++;
    if (err_stray !== 1'b1 || mv_hi != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL stray_flag got err=%b mv_cycles=%0d busy=%b want 1 0 0", err_stray,
               mv_hi, busy);
    end
    n_checks++;
    if (bus.m_data !== last_res) begin
      n_fail++;
      $display("FAIL stray_m_data got %h want %h", bus.m_data, last_res);
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] d;
    int unsigned   c;
    bit            acc, ok;
    clear_mon();
    lat = 67;
    resp_en = 1'b1;
    bus.m_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(DW'($urandom()), c, acc);
    bus.s_valid = 1'b0;
    for (int i = 0; i < 10; i++) step();
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.s_ready, bus.fir_input_valid, bus.m_valid, busy, err_timeout, err_stray}
        !== 6'b100000 || bus.fir_in_data !== '0 || bus.m_data !== '0) begin
      n_fail++;
      $display("FAIL rst_async got flags %b fir_in %h m_data %h want 100000 0 0",
               {bus.s_ready, bus.fir_input_valid, bus.m_valid, busy, err_timeout, err_stray},
               bus.fir_in_data, bus.m_data);
    end
    step();
    step();
    rst = 1'b0;
    clear_mon();
    for (int i = 0; i < 30; i++) step();
    n_checks++;
    if (pulse_q.size() != 0 || bus.s_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_flushed got pulses=%0d s_ready=%b busy=%b want 0 1 0",
               pulse_q.size(), bus.s_ready, busy);
    end
    d = DW'($urandom());
    push(d, c, acc);
    bus.s_valid = 1'b0;
    wait_results(1, 120, ok);
    n_checks++;
    if (!ok || pulse_q[0] != c + 2 || got_q[0] !== fir_model(d)) begin
      n_fail++;
      $display("FAIL rst_resume got pulse %0d result %h want %0d %h",
               (pulse_q.size() > 0) ? pulse_q[0] : 0, (got_q.size() > 0) ? got_q[0] : 'x,
               c + 2, fir_model(d));
    end
  endtask

  initial begin
    logic [OW-1:0] last_res;
    test_reset();
    test_single();
    test_burst();
    test_back_pressure();
    test_timeout_boundary();
    test_timeout();
    last_res = (got_q.size() > 0) ? got_q[got_q.size()-1] : '0;
    test_stray(last_res);
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
